// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control sequencer: drives ALU, register file, IR and the unified
// memory port through fetch/decode/execute/memory/writeback, stalling on mem_ready.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4, wait for mem_ready
  // DECODE   | compute branch target OldPC+imm, dispatch on opcode
  // MEMADR   | rs1+imm address for lw/sw
  // MEMREAD  | load access, wait for mem_ready
  // MEMWB    | write loaded data to rd
  // MEMWRITE | store access, wait for mem_ready
  // EXECUTER | register-register ALU op
  // EXECUTEI | register-immediate ALU op
  // ALUWB    | write ALUOut to rd (also jal link)
  // BEQ      | compare, take branch on zero
  // JAL      | load jump target, compute link OldPC+4
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state_q, state_d;
  aluop_t alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // Write enables and pulses stay quiet for the whole reset, regardless of state.
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALU_SUB: alu_control = 3'b001;
      ALU_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle vector bench for multicycle_ctrl plus latency checks.
module tb_multicycle_ctrl;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .retire(retire), .illegal(illegal),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // exp = {state, pc_write/adr_src/mem_write/ir_write, result_src, alu_src_a,
  //        alu_src_b, alu_control, imm_src, reg_write/retire/illegal}
  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z, rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [3:0] en, input logic [1:0] rs,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ac,
                     input logic [1:0] im, input logic [2:0] wr);
    vec_t v;
    v.rst_n = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
    v.exp = {st, en, rs, sa, sb, ac, im, wr};
    vecs.push_back(v);
  endtask

  function automatic logic [21:0] actual();
    return {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
            alu_src_b, alu_control, imm_src, reg_write, retire, illegal};
  endfunction

  task automatic run_lat(input string name, input logic [6:0] o, input logic [2:0] f3,
                         input int stall, input int exp_cyc);
    int  cyc;
    bit  seen;
    cyc = 0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      rst_n = 1'b1; op = o; funct3 = f3; funct7 = 1'b0; zero = 1'b0;
      mem_ready = (c < stall) ? 1'b0 : 1'b1;
      #1;
      cyc++;
      if (retire) seen = 1;
    end
    total++;
    if (!seen || cyc != exp_cyc) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles (retire seen=%0d), want %0d", name, cyc, seen, exp_cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0; op = LW; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    add(0, LW, 2, 0, 0, 1, 0, 4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    // lw, no wait
    add(1, LW, 2, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 1, 2, 4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 1, 3, 4'b0100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 1, 4, 4'b0000, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 3'b110);
    // sw, two wait cycles in MEMWRITE
    add(1, SW, 2, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 1, 2, 4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 0, 5, 4'b0110, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 0, 5, 4'b0110, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 1, 5, 4'b0110, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b010);
    // R-type sub, one wait cycle in FETCH
    add(1, RT, 0, 1, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, RT, 0, 1, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, RT, 0, 1, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, RT, 0, 1, 0, 1, 6, 4'b0000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000);
    add(1, RT, 0, 1, 0, 1, 8, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b110);
    // addi with funct7=1 stays add
    add(1, IT, 0, 1, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, IT, 0, 1, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, IT, 0, 1, 0, 1, 7, 4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, IT, 0, 1, 0, 1, 8, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b110);
    // and
    add(1, RT, 7, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, RT, 7, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, RT, 7, 0, 0, 1, 6, 4'b0000, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 3'b000);
    add(1, RT, 7, 0, 0, 1, 8, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b110);
    // or, mem_ready low where it must be ignored
    add(1, RT, 6, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, RT, 6, 0, 0, 0, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, RT, 6, 0, 0, 0, 6, 4'b0000, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 3'b000);
    add(1, RT, 6, 0, 0, 0, 8, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b110);
    // slti
    add(1, IT, 2, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, IT, 2, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, IT, 2, 0, 0, 1, 7, 4'b0000, 2'b00, 2'b10, 2'b01, 3'b101, 2'b00, 3'b000);
    add(1, IT, 2, 0, 0, 1, 8, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b110);
    // beq taken
    add(1, BQ, 0, 0, 1, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000);
    add(1, BQ, 0, 0, 1, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 3'b000);
    add(1, BQ, 0, 0, 1, 1, 9, 4'b1000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 3'b010);
    // beq not taken
    add(1, BQ, 0, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000);
    add(1, BQ, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 3'b000);
    add(1, BQ, 0, 0, 0, 1, 9, 4'b0000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 3'b010);
    // jal
    add(1, JL, 0, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11, 3'b000);
    add(1, JL, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11, 3'b000);
    add(1, JL, 0, 0, 0, 1, 10, 4'b1000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 3'b000);
    add(1, JL, 0, 0, 0, 1, 8, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 3'b110);
    // illegal opcode
    add(1, BAD, 0, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, BAD, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b001);
    // reset during MEMREAD wait
    add(1, LW, 2, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 1, 2, 4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000);
    add(1, LW, 2, 0, 0, 0, 3, 4'b0100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);
    add(0, LW, 2, 0, 0, 0, 3, 4'b0100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);
    add(0, LW, 2, 0, 0, 1, 0, 4'b0000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000);
    // resume, then reset during MEMWRITE wait (mem_write must drop)
    add(1, SW, 2, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 1, 2, 4'b0000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 0, 5, 4'b0110, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000);
    add(0, SW, 2, 0, 0, 1, 5, 4'b0100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000);
    add(1, SW, 2, 0, 0, 1, 0, 4'b1001, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000);
    add(1, BAD, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b001);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      logic [21:0] act;
      @(negedge clk);
      rst_n = vecs[i].rst_n; op = vecs[i].op; funct3 = vecs[i].f3;
      funct7 = vecs[i].f7; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      act = actual();
      total++;
      if (act !== vecs[i].exp) begin
        bad++;
        $display("FAIL vec%0d: got %b want %b (state/en/rs/sa/sb/alu/imm/wr)", i, act, vecs[i].exp);
      end
    end

    // Each latency run starts from FETCH and ends back in FETCH.
    run_lat("lw", LW, 3'd2, 0, 5);
    run_lat("lw_stall2", LW, 3'd2, 2, 7);
    run_lat("sw", SW, 3'd2, 0, 4);
    run_lat("beq", BQ, 3'd0, 0, 3);
    run_lat("jal", JL, 3'd0, 0, 4);
    run_lat("addi", IT, 3'd0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
